// File: rtl/if_pkg.sv
// if_pkg: shared types for the fetch stage and its branch target buffer.
package if_pkg;
  typedef enum logic {RUN, HALTED} state_t;
  localparam logic [1:0] SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  localparam int MAX_XLEN = 64;
  // Tag is stored zero-extended to MAX_XLEN so one struct serves every XLEN.
  typedef struct packed {
    logic [MAX_XLEN-1:0] tag;
    logic [1:0]          cnt;
  } btb_ent_t;
endpackage

// File: rtl/if_btb.sv
// if_btb: direct-mapped BTB with combinational lookup and 2-bit counter update.
module if_btb import if_pkg::*; #(
  parameter int XLEN = 32,
  parameter int INST_BYTES = 4,
  parameter int BTB_ENTRIES = 16,
  localparam int OW = $clog2(INST_BYTES),
  localparam int IW = $clog2(BTB_ENTRIES),
  localparam int AW = XLEN - OW
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_lk_addr,
  input  logic            i_upd_valid,
  input  logic [AW-1:0]   i_upd_addr,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target
);
  logic [BTB_ENTRIES-1:0] r_valid;
  btb_ent_t               r_ent [BTB_ENTRIES];
  logic [XLEN-1:0]        r_tgt [BTB_ENTRIES];
  logic [IW-1:0]          w_lk_idx, w_up_idx;
  logic [MAX_XLEN-1:0]    w_lk_tag, w_up_tag;
  logic                   w_lk_hit, w_up_hit;
  logic [1:0]             w_cnt, w_cnt_nxt;
  always_comb begin
    w_lk_idx      = i_lk_addr[IW-1:0];
    w_up_idx      = i_upd_addr[IW-1:0];
    w_lk_tag      = MAX_XLEN'(i_lk_addr[AW-1:IW]);
    w_up_tag      = MAX_XLEN'(i_upd_addr[AW-1:IW]);
    w_lk_hit      = r_valid[w_lk_idx] && r_ent[w_lk_idx].tag == w_lk_tag;
    w_up_hit      = r_valid[w_up_idx] && r_ent[w_up_idx].tag == w_up_tag;
    o_pred_taken  = w_lk_hit && r_ent[w_lk_idx].cnt[1];
    o_pred_target = r_tgt[w_lk_idx];
    w_cnt         = r_ent[w_up_idx].cnt;
    w_cnt_nxt     = i_upd_taken ? (w_cnt == ST ? ST : w_cnt + 2'd1)
                                : (w_cnt == SNT ? SNT : w_cnt - 2'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_valid <= '0;
    else if (i_upd_valid && i_upd_taken)
      r_valid[w_up_idx] <= 1'b1;
  end
  // A not-taken miss leaves the entry untouched; a taken miss allocates weakly taken.
  always_ff @(posedge clk) begin
    if (i_upd_valid && (w_up_hit || i_upd_taken)) begin
      r_ent[w_up_idx] <= '{tag: w_up_tag, cnt: w_up_hit ? w_cnt_nxt : WT};
      if (i_upd_taken)
        r_tgt[w_up_idx] <= i_upd_target;
    end
  end
endmodule

// File: rtl/if_btb_fetch.sv
// if_btb_fetch: fetch PC register with RUN/HALTED control and BTB-driven next-PC.
module if_btb_fetch import if_pkg::*; #(
  parameter int XLEN = 32,
  parameter int INST_BYTES = 4,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);
  localparam int OW = $clog2(INST_BYTES);
  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  if_btb #(.XLEN(XLEN), .INST_BYTES(INST_BYTES), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lk_addr    (r_pc[XLEN-1:OW]),
    .i_upd_valid  (upd_valid),
    .i_upd_addr   (upd_pc[XLEN-1:OW]),
    .i_upd_taken  (upd_taken),
    .i_upd_target (upd_target),
    .o_pred_taken (pred_taken),
    .o_pred_target(pred_target)
  );
  always_comb begin
    w_state_nxt = flush ? RUN : halt ? HALTED : r_state;
    w_pc_nxt    = flush ? flush_pc
                : (halt || r_state == HALTED || stall) ? r_pc
                : pred_taken ? pred_target
                : r_pc + XLEN'(INST_BYTES);
    fetch_valid = r_state == RUN && !stall;
    pc          = r_pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end
endmodule

// File: tb/tb_if_btb_fetch.sv
// tb_if_btb_fetch: directed stimulus checked every cycle against an array-based BTB/PC model.
module tb_if_btb_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt = 1'b0, flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [31:0] pc, pred_target;
  logic        fetch_valid, pred_taken;
  logic [7:0]  pc8, tg8;
  logic        fv8, pt8;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  if_btb_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .flush(flush), .flush_pc(flush_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .fetch_valid(fetch_valid), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  if_btb_fetch #(.XLEN(8), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .rst(rst), .stall(1'b0), .halt(1'b0), .flush(1'b0), .flush_pc(8'h00),
    .upd_valid(1'b0), .upd_pc(8'h00), .upd_taken(1'b0), .upd_target(8'h00),
    .pc(pc8), .fetch_valid(fv8), .pred_taken(pt8), .pred_target(tg8)
  );

  // Behavioural model: entries indexed by (pc/4)%16, tag pc/64.
  bit          m_v [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  logic [31:0] m_pc;
  bit          m_halted;

  function automatic bit m_hit(input logic [31:0] a);
    int i = int'((a / 4) % 16);
    return m_v[i] && m_tag[i] == a / 64;
  endfunction

  function automatic bit m_pt(input logic [31:0] a);
    return m_hit(a) && m_cnt[(a / 4) % 16] >= 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0;
      m_halted <= 1'b0;
      for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
    end else begin
      if (flush) m_pc <= flush_pc;
      else if (halt || m_halted || stall) m_pc <= m_pc;
      else if (m_pt(m_pc)) m_pc <= m_tgt[(m_pc / 4) % 16];
      else m_pc <= m_pc + 32'd4;
      m_halted <= flush ? 1'b0 : (halt ? 1'b1 : m_halted);
      if (upd_valid) begin
        if (m_hit(upd_pc)) begin
          m_cnt[(upd_pc / 4) % 16] <= upd_taken ? ((m_cnt[(upd_pc / 4) % 16] + 1 > 3) ? 3 : m_cnt[(upd_pc / 4) % 16] + 1)
                                                : ((m_cnt[(upd_pc / 4) % 16] - 1 < 0) ? 0 : m_cnt[(upd_pc / 4) % 16] - 1);
          if (upd_taken) m_tgt[(upd_pc / 4) % 16] <= upd_target;
        end else if (upd_taken) begin
          m_v[(upd_pc / 4) % 16]   <= 1'b1;
          m_tag[(upd_pc / 4) % 16] <= upd_pc / 64;
          m_tgt[(upd_pc / 4) % 16] <= upd_target;
          m_cnt[(upd_pc / 4) % 16] <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (pc !== m_pc) begin bad++; $display("FAIL model_pc got=%h want=%h", pc, m_pc); end
      total++;
      if (fetch_valid !== (!m_halted && !stall)) begin
        bad++; $display("FAIL model_fv got=%b want=%b", fetch_valid, !m_halted && !stall);
      end
      total++;
      if (pred_taken !== m_pt(m_pc)) begin bad++; $display("FAIL model_pt got=%b want=%b pc=%h", pred_taken, m_pt(m_pc), m_pc); end
      if (m_pt(m_pc)) begin
        total++;
        if (pred_target !== m_tgt[(m_pc / 4) % 16]) begin
          bad++; $display("FAIL model_tgt got=%h want=%h", pred_target, m_tgt[(m_pc / 4) % 16]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%h want=%h", name, act, exp); end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [31:0] a, input logic t, input logic [31:0] g);
    upd_valid = v; upd_pc = a; upd_taken = t; upd_target = g;
  endtask

  task automatic redirect(input logic [31:0] a);
    flush = 1'b1; flush_pc = a;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h1);
    chk("rst_pt", {31'b0, pred_taken}, 32'h0);
    chk("pc8_reset", {24'b0, pc8}, 32'hFC);
    cyc(); chk("seq_4", pc, 32'h4); chk("pc8_wrap", {24'b0, pc8}, 32'h00);
    cyc(); chk("seq_8", pc, 32'h8); chk("pc8_after_wrap", {24'b0, pc8}, 32'h04);
    cyc(); chk("seq_c", pc, 32'hC);
    upd(1, 32'h10, 1, 32'h80);
    cyc(); upd(0, 0, 0, 0);
    chk("hit_pc", pc, 32'h10);
    chk("hit_pt", {31'b0, pred_taken}, 32'h1);
    chk("hit_tgt", pred_target, 32'h80);
    cyc(); chk("jump_80", pc, 32'h80);
    upd(1, 32'h10, 0, 0);
    cyc(2); upd(0, 0, 0, 0);
    redirect(32'h10);
    chk("nt_pt", {31'b0, pred_taken}, 32'h0);
    cyc(); chk("nt_seq", pc, 32'h14);
    upd(1, 32'h18, 1, 32'h100);
    cyc(); upd(0, 0, 0, 0);
    chk("pt18", {31'b0, pred_taken}, 32'h1);
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h200;
    cyc(); flush = 1'b0;
    chk("flush_prio", pc, 32'h200);
    cyc(); chk("stall_hold", pc, 32'h200);
    stall = 1'b0;
    cyc(); chk("stall_rel", pc, 32'h204);
    redirect(32'h24);
    halt = 1'b1;
    cyc(); halt = 1'b0;
    chk("halt_pc", pc, 32'h24);
    chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
    cyc(); halt = 1'b1;
    cyc(); halt = 1'b0; stall = 1'b1;
    cyc(); stall = 1'b0;
    chk("halt_hold", pc, 32'h24);
    redirect(32'h40);
    chk("unhalt_pc", pc, 32'h40);
    chk("unhalt_fv", {31'b0, fetch_valid}, 32'h1);
    redirect(32'h10);
    upd(1, 32'h50, 1, 32'h90);
    cyc(); upd(0, 0, 0, 0);
    chk("alias_pre", pc, 32'h14);
    redirect(32'h10);
    chk("alias_miss", {31'b0, pred_taken}, 32'h0);
    redirect(32'h50);
    chk("alias_hit", {31'b0, pred_taken}, 32'h1);
    upd(1, 32'h50, 0, 0);
    cyc(); upd(0, 0, 0, 0);
    chk("same_cyc_upd", pc, 32'h90);
    upd(1, 32'h50, 1, 32'h120);
    cyc(3); upd(1, 32'h50, 0, 0);
    cyc(); upd(0, 0, 0, 0);
    redirect(32'h50);
    chk("sat_pt", {31'b0, pred_taken}, 32'h1);
    chk("sat_tgt", pred_target, 32'h120);
    cyc(); chk("sat_jump", pc, 32'h120);
    #3 rst = 1'b1;
    #1 chk("async_rst_pc", pc, 32'h0);
    cyc(); rst = 1'b0;
    cyc(4); chk("rst_clears_btb", pc, 32'h10);
    chk("rst_clears_pt", {31'b0, pred_taken}, 32'h0);
    cyc(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
